// File: rtl/arm_decode_stage.sv
`default_nettype none
// ============================================================================
//  Module      : arm_decode_stage
//  Description : ARM instruction decode stage between fetch and the execute
//                ALU. Splits each accepted instruction word into class,
//                opcode, condition, S bit, register indices and expanded
//                immediate, and holds the result behind a valid/ready
//                handshake. Optional macro DECODE_SKID_EN adds a second
//                (skid) entry so if_ready comes from registered state only.
//  Revision    : 1.0 - initial release
// ============================================================================
module arm_decode_stage (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        if_valid,
    input  logic [31:0] if_inst,
    input  logic [31:0] if_pc,
    output logic        if_ready,
    input  logic        flush,
    input  logic        ex_ready,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [2:0]  instruction_codes,
    output logic [3:0]  opcode,
    output logic [3:0]  cond,
    output logic        s_bit,
    output logic [3:0]  rn,
    output logic [3:0]  rd,
    output logic [3:0]  rm,
    output logic        use_imm,
    output logic [31:0] imm_val,
    output logic        is_branch,
    output logic        link,
    output logic [31:0] branch_off
);

    typedef struct packed {
        logic [31:0] pc;
        logic [2:0]  codes;
        logic [3:0]  opcode;
        logic [3:0]  cond;
        logic        s_bit;
        logic [3:0]  rn;
        logic [3:0]  rd;
        logic [3:0]  rm;
        logic        use_imm;
        logic [31:0] imm_val;
        logic        is_branch;
        logic        link;
        logic [31:0] branch_off;
    } dec_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    dec_t        w_dec;
    dec_t        r_out;
    logic        w_accept;
    logic        w_consume;
    logic        w_load_new;
    logic [31:0] w_imm8;
    logic [4:0]  w_rot;
`ifdef DECODE_SKID_EN
    dec_t        r_skid;
    logic        w_load_skid;
    logic        w_skid_to_out;
`endif

    assign id_valid  = (r_state != ST_EMPTY);
`ifdef DECODE_SKID_EN
    assign if_ready  = (r_state != ST_SKID) & ~flush;
`else
    assign if_ready  = (~id_valid | ex_ready) & ~flush;
`endif
    assign w_accept  = if_valid & if_ready;
    assign w_consume = id_valid & ex_ready;

    // Rotate right by 2*rot4; the (-rot) left shift degenerates to a no-op OR when rot is 0.
    assign w_imm8 = {24'd0, if_inst[7:0]};
    assign w_rot  = {if_inst[11:8], 1'b0};

    // Combinational field split of the instruction currently offered by fetch.
    always_comb begin
        w_dec            = '0;
        w_dec.pc         = if_pc;
        w_dec.codes      = if_inst[27:25];
        w_dec.opcode     = if_inst[24:21];
        w_dec.cond       = if_inst[31:28];
        w_dec.s_bit      = if_inst[20];
        w_dec.rn         = if_inst[19:16];
        w_dec.rd         = if_inst[15:12];
        w_dec.rm         = if_inst[3:0];
        case (if_inst[27:25])
            3'b001: begin
                w_dec.use_imm = 1'b1;
                w_dec.imm_val = (w_imm8 >> w_rot) | (w_imm8 << (~w_rot + 5'd1));
            end
            3'b010: begin
                w_dec.use_imm = 1'b1;
                w_dec.imm_val = {20'd0, if_inst[11:0]};
            end
            3'b101: begin
                w_dec.is_branch  = 1'b1;
                w_dec.link       = if_inst[24];
                w_dec.branch_off = {{6{if_inst[23]}}, if_inst[23:0], 2'b00};
            end
            default: ;
        endcase
    end

    // Next-state and register-load control for the holding/skid buffer.
    always_comb begin
        w_state_next  = r_state;
        w_load_new    = 1'b0;
`ifdef DECODE_SKID_EN
        w_load_skid   = 1'b0;
        w_skid_to_out = 1'b0;
`endif
        case (r_state)
            ST_EMPTY: begin
                if (w_accept) begin
                    w_state_next = ST_FULL;
                    w_load_new   = 1'b1;
                end
            end
            ST_FULL: begin
`ifdef DECODE_SKID_EN
                if (w_accept && !w_consume) begin
                    w_state_next = ST_SKID;
                    w_load_skid  = 1'b1;
                end else if (w_accept) begin
                    w_load_new   = 1'b1;
                end else if (w_consume) begin
                    w_state_next = ST_EMPTY;
                end
`else
                if (w_accept) begin
                    w_load_new   = 1'b1;
                end else if (w_consume) begin
                    w_state_next = ST_EMPTY;
                end
`endif
            end
`ifdef DECODE_SKID_EN
            ST_SKID: begin
                if (w_consume) begin
                    w_state_next  = ST_FULL;
                    w_skid_to_out = 1'b1;
                end
            end
`endif
            default: w_state_next = ST_EMPTY;
        endcase
        // A taken branch invalidates everything held here.
        if (flush) begin
            w_state_next = ST_EMPTY;
        end
    end

    // State and data registers; reset clears every output field.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= ST_EMPTY;
            r_out   <= '0;
`ifdef DECODE_SKID_EN
            r_skid  <= '0;
`endif
        end else begin
            r_state <= w_state_next;
            if (w_load_new) begin
                r_out <= w_dec;
            end
`ifdef DECODE_SKID_EN
            else if (w_skid_to_out) begin
                r_out <= r_skid;
            end
            if (w_load_skid) begin
                r_skid <= w_dec;
            end
`endif
        end
    end

    assign id_pc             = r_out.pc;
    assign instruction_codes = r_out.codes;
    assign opcode            = r_out.opcode;
    assign cond              = r_out.cond;
    assign s_bit             = r_out.s_bit;
    assign rn                = r_out.rn;
    assign rd                = r_out.rd;
    assign rm                = r_out.rm;
    assign use_imm           = r_out.use_imm;
    assign imm_val           = r_out.imm_val;
    assign is_branch         = r_out.is_branch;
    assign link              = r_out.link;
    assign branch_off        = r_out.branch_off;

endmodule
`default_nettype wire

// File: tb/tb_arm_decode_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_arm_decode_stage
//  Description : Self-checking bench for arm_decode_stage. Expected decode
//                records are queued on each observed input transfer and
//                compared in order on each output transfer; directed field
//                checks cover the listed instruction examples. Honours
//                DECODE_SKID_EN for the occupancy expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_arm_decode_stage;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        if_valid = 1'b0;
    logic [31:0] if_inst = '0;
    logic [31:0] if_pc = '0;
    logic        if_ready;
    logic        flush = 1'b0;
    logic        ex_ready = 1'b0;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [2:0]  instruction_codes;
    logic [3:0]  opcode;
    logic [3:0]  cond;
    logic        s_bit;
    logic [3:0]  rn;
    logic [3:0]  rd;
    logic [3:0]  rm;
    logic        use_imm;
    logic [31:0] imm_val;
    logic        is_branch;
    logic        link;
    logic [31:0] branch_off;

    arm_decode_stage dut (
        .clk(clk), .reset_n(reset_n),
        .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc), .if_ready(if_ready),
        .flush(flush), .ex_ready(ex_ready),
        .id_valid(id_valid), .id_pc(id_pc), .instruction_codes(instruction_codes),
        .opcode(opcode), .cond(cond), .s_bit(s_bit), .rn(rn), .rd(rd), .rm(rm),
        .use_imm(use_imm), .imm_val(imm_val), .is_branch(is_branch), .link(link),
        .branch_off(branch_off)
    );

    always #5 clk = ~clk;

`ifdef DECODE_SKID_EN
    localparam int EXP_HELD = 2;
`else
    localparam int EXP_HELD = 1;
`endif

    int           checks = 0;
    int           failures = 0;
    int           pops = 0;
    logic [122:0] sb [$];
    logic [122:0] obs;

    assign obs = {id_pc, instruction_codes, opcode, cond, s_bit, rn, rd, rm,
                  use_imm, imm_val, is_branch, link, branch_off};

    // Reference decode written from the instruction-set description.
    function automatic logic [122:0] model(input logic [31:0] i, input logic [31:0] pc);
        logic [31:0] imm;
        logic [31:0] off;
        logic        ui;
        logic        br;
        logic        lk;
        int          n;
        imm = '0; off = '0; ui = 1'b0; br = 1'b0; lk = 1'b0;
        case (i[27:25])
            3'b001: begin
                ui  = 1'b1;
                imm = {24'd0, i[7:0]};
                n   = 2 * int'(i[11:8]);
                for (int k = 0; k < n; k++) imm = {imm[0], imm[31:1]};
            end
            3'b010: begin
                ui  = 1'b1;
                imm = {20'd0, i[11:0]};
            end
            3'b101: begin
                br  = 1'b1;
                lk  = i[24];
                off = {{6{i[23]}}, i[23:0], 2'b00};
            end
            default: ;
        endcase
        return {pc, i[27:25], i[24:21], i[31:28], i[20], i[19:16], i[15:12], i[3:0],
                ui, imm, br, lk, off};
    endfunction

    task automatic chk(input string tag, input logic [122:0] got, input logic [122:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // One clock of stimulus; scoreboard bookkeeping happens at the falling edge.
    task automatic step(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                        input logic exr, input logic fl, output logic acc);
        if_valid = v; if_inst = inst; if_pc = pc; ex_ready = exr; flush = fl;
        @(negedge clk);
        acc = v & if_ready;
        if (id_valid && exr) begin
            pops++;
            if (sb.size() == 0) chk("unexpected_output", id_valid, 1'b0);
            else chk("sb_out", obs, sb.pop_front());
        end
        if (fl) sb.delete();
        else if (acc) sb.push_back(model(inst, pc));
        @(posedge clk);
        #1;
    endtask

    logic [31:0] stall_inst [4];
    logic        acc;
    int          k;
    int          p0;
    logic [31:0] pc;

    initial begin
        stall_inst[0] = 32'hE2811005;
        stall_inst[1] = 32'hE0512003;
        stall_inst[2] = 32'hE59F1010;
        stall_inst[3] = 32'hEB000010;

        // Reset held for two edges while fetch offers an instruction.
        reset_n = 1'b0; if_valid = 1'b1; if_inst = 32'hE2811005; if_pc = 32'h40; ex_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_id_valid", id_valid, 1'b0);
        chk("reset_fields", obs, '0);
        reset_n = 1'b1; if_valid = 1'b0;
        #1;
        chk("reset_if_ready", if_ready, 1'b1);

        // ADD r1, r1, #5
        step(1'b1, 32'hE2811005, 32'h100, 1'b1, 1'b0, acc);
        chk("add_valid", id_valid, 1'b1);
        chk("add_class", instruction_codes, 3'b001);
        chk("add_opcode", opcode, 4'b0100);
        chk("add_cond", cond, 4'b1110);
        chk("add_s", s_bit, 1'b0);
        chk("add_rn_rd", {rn, rd}, 8'h11);
        chk("add_imm", {use_imm, imm_val}, {1'b1, 32'd5});
        chk("add_pc", id_pc, 32'h100);

        // MOV r0, #0xFF000000 (rotated immediate)
        step(1'b1, 32'hE3A004FF, 32'h104, 1'b1, 1'b0, acc);
        chk("mov_opcode", opcode, 4'b1101);
        chk("mov_imm", imm_val, 32'hFF000000);

        // SUBS r2, r1, r3 followed immediately by B .
        step(1'b1, 32'hE0512003, 32'h108, 1'b1, 1'b0, acc);
        chk("subs_opcode_s", {opcode, s_bit}, {4'b0010, 1'b1});
        chk("subs_regs", {rn, rd, rm}, 12'h123);
        chk("subs_use_imm", use_imm, 1'b0);
        step(1'b1, 32'hEAFFFFFE, 32'h10C, 1'b1, 1'b0, acc);
        chk("b_branch_link", {is_branch, link}, 2'b10);
        chk("b_off", branch_off, 32'hFFFFFFF8);
        chk("b_imm", {use_imm, imm_val}, '0);
        step(1'b0, '0, '0, 1'b1, 1'b0, acc);
        chk("drain_empty", id_valid, 1'b0);

        // Stall: execute blocked for three cycles while four instructions stream.
        p0 = pops; k = 0;
        for (int c = 0; c < 3; c++) begin
            step(1'b1, stall_inst[k], 32'h200 + 32'(4 * k), 1'b0, 1'b0, acc);
            if (acc) k++;
        end
        chk("stall_held", sb.size(), EXP_HELD);
        chk("stall_if_ready", if_ready, 1'b0);
        chk("stall_stable_pc", id_pc, 32'h200);
        for (int c = 0; c < 12 && k < 4; c++) begin
            step(1'b1, stall_inst[k], 32'h200 + 32'(4 * k), 1'b1, 1'b0, acc);
            if (acc) k++;
        end
        for (int c = 0; c < 6 && (sb.size() != 0 || id_valid); c++)
            step(1'b0, '0, '0, 1'b1, 1'b0, acc);
        chk("stall_all_out", pops - p0, 4);

        // Flush while full (skid occupied in the skid build) with fetch offering.
        step(1'b1, 32'hE2822001, 32'h300, 1'b0, 1'b0, acc);
        step(1'b1, 32'hE2833002, 32'h304, 1'b0, 1'b0, acc);
        step(1'b1, 32'hE2844003, 32'h308, 1'b0, 1'b1, acc);
        chk("flush_no_accept", acc, 1'b0);
        chk("flush_id_valid", id_valid, 1'b0);
        step(1'b1, 32'hE3A05007, 32'h400, 1'b0, 1'b0, acc);
        chk("post_flush_accept", acc, 1'b1);
        chk("post_flush_pc", id_pc, 32'h400);
        step(1'b0, '0, '0, 1'b1, 1'b0, acc);
        chk("post_flush_alone", {id_valid, 32'(sb.size())}, '0);

        // Random traffic with occasional flushes.
        pc = 32'h1000;
        for (int c = 0; c < 150; c++) begin
            step(($urandom % 4) != 0, $urandom, pc, ($urandom % 3) != 0,
                 ($urandom % 16) == 0, acc);
            pc += 4;
        end
        for (int c = 0; c < 6 && (sb.size() != 0 || id_valid); c++)
            step(1'b0, '0, '0, 1'b1, 1'b0, acc);
        chk("final_empty", {id_valid, 32'(sb.size())}, '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
